mem_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU (read/write/address/mem_out strobes), port 1 is a DMA/loader engine.
- Sequences each access through a fixed request/grant/access/response FSM and returns read data with a one-cycle ack pulse.
- Sits between the CPU memory interface and the memory macro.
- Arbitration is round-robin by default.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports, the memory-side strobes and status.
// The arbiter uses the slave modport; requesters/memory (or a bench) use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_rd;
  logic              p0_wr;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_rd;
  logic              p1_wr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              err;

  modport slave (
    input  p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p1_rd, p1_wr, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, err
  );

  modport master (
    output p0_rd, p0_wr, p0_addr, p0_wdata,
    output p1_rd, p1_wr, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-port data memory: IDLE -> ACCESS -> RESP per access.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst_b,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_reg;
  logic                     win_id_reg;
  logic                     holdoff_reg;
  logic                     mem_en_reg;
  logic                     mem_we_reg;
  logic [ADDR_W-1:0]        mem_addr_reg;
  logic [DATA_W-1:0]        mem_wdata_reg;
  logic [1:0]               ack_reg;
  logic [1:0][DATA_W-1:0]   rdata_reg;
  logic                     busy_reg;
  logic                     err_reg;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                     last_grant_reg;
`endif

  logic [1:0]               rd_req;
  logic [1:0]               wr_req;
  logic [1:0]               elig;
  logic [1:0]               dual;
  logic [ADDR_W-1:0]        addr_req  [2];
  logic [DATA_W-1:0]        wdata_req [2];
  logic                     any_elig;
  logic                     win_next;

  assign rd_req       = {bus.p1_rd, bus.p0_rd};
  assign wr_req       = {bus.p1_wr, bus.p0_wr};
  assign addr_req[0]  = bus.p0_addr;
  assign addr_req[1]  = bus.p1_addr;
  assign wdata_req[0] = bus.p0_wdata;
  assign wdata_req[1] = bus.p1_wdata;

  // The port acked last cycle sits out one IDLE so it can drop its request.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign elig[gi] = (rd_req[gi] | wr_req[gi]) & ~(holdoff_reg & (win_id_reg == 1'(gi)));
      assign dual[gi] = rd_req[gi] & wr_req[gi];
    end
  endgenerate

  assign any_elig = |elig;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win_next = ~elig[0];
`else
  assign win_next = (elig == 2'b11) ? ~last_grant_reg : elig[1];
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg      <= IDLE;
      win_id_reg     <= 1'b0;
      holdoff_reg    <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      ack_reg     <= '0;
      holdoff_reg <= 1'b0;
      if (state_reg == IDLE && (|dual)) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (any_elig) begin
            // rd+wr together falls through as a write since wr selects the op.
            win_id_reg     <= win_next;
            mem_we_reg     <= wr_req[win_next];
            mem_addr_reg   <= addr_req[win_next];
            mem_wdata_reg  <= wdata_req[win_next];
            mem_en_reg     <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ACCESS;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_reg <= win_next;
`endif
          end
        end
        ACCESS: begin
          mem_en_reg          <= 1'b0;
          mem_we_reg          <= 1'b0;
          ack_reg[win_id_reg] <= 1'b1;
          if (!mem_we_reg) begin
            rdata_reg[win_id_reg] <= bus.mem_rdata;
          end
          state_reg <= RESP;
        end
        RESP: begin
          busy_reg    <= 1'b0;
          holdoff_reg <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.p0_ack    = ack_reg[0];
  assign bus.p1_ack    = ack_reg[1];
  assign bus.p0_rdata  = rdata_reg[0];
  assign bus.p1_rdata  = rdata_reg[1];
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, ack scoreboard, and
// hand sequences for contention, mid-access reset and late address change.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_b;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data presented while a read strobe is active.
  bit   [15:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 16'h0000;

  typedef struct {
    bit          port;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          late;
    logic [15:0] late_addr;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          port;
    logic [15:0] rdata;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {10'b0, bus.p0_ack, bus.p1_ack, bus.p0_rdata, bus.p1_rdata, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.err};
  endfunction

  task automatic drive_port(input bit p, input bit rd, input bit wr,
                            input logic [15:0] addr, input logic [15:0] wdata);
    if (p) begin
      bus.p1_rd = rd; bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_rd = rd; bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge clk) begin
    if (rst_b && (bus.p0_ack || bus.p1_ack)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {bus.p1_ack, bus.p0_ack}, 80'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("ack_port", {bus.p1_ack, bus.p0_ack}, e.port ? 80'd2 : 80'd1);
        check("rdata", e.port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
        $display("ack port%0d rdata=%h expected=%h", e.port,
                 e.port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
      end
    end
  end

  // One access: request seen at d0, mem_en at d1, ack at d2, idle at d3.
  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    drive_port(v.port, v.rd, v.wr, v.addr, v.wdata);
    e.port = v.port; e.rdata = v.exp_rdata;
    sb.push_back(e);
    @(negedge clk);
    check("mem_en", bus.mem_en, 80'd1);
    check("mem_we", bus.mem_we, v.wr);
    check("mem_addr", bus.mem_addr, v.addr);
    if (v.wr) check("mem_wdata", bus.mem_wdata, v.wdata);
    check("busy_access", bus.busy, 80'd1);
    if (v.late) drive_port(v.port, v.rd, v.wr, v.late_addr, v.wdata);
    @(negedge clk);
    check("ack_cycle", {bus.p1_ack, bus.p0_ack}, v.port ? 80'd2 : 80'd1);
    check("mem_en_resp", bus.mem_en, 80'd0);
    drive_port(v.port, 1'b0, 1'b0, v.addr, v.wdata);
    @(negedge clk);
    check("idle_after", {bus.busy, bus.p1_ack, bus.p0_ack, bus.mem_en}, 80'd0);
    check("err", bus.err, v.exp_err);
  endtask

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    int  n_en, n_ack, last_en, last_ack;

    tbl[0]  = '{0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'hBEEF, 0};
    tbl[1]  = '{1, 0, 1, 16'h0200, 16'h1234, 0, 16'h0000, 16'h2222, 0};
    tbl[2]  = '{0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 16'h1234, 0};
    tbl[3]  = '{1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'hBEEF, 0};
    tbl[4]  = '{0, 0, 1, 16'h0033, 16'h5A5A, 0, 16'h0000, 16'h1234, 0};
    tbl[5]  = '{1, 1, 0, 16'h0033, 16'h0000, 0, 16'h0000, 16'h5A5A, 0};
    tbl[6]  = '{1, 0, 1, 16'hFFFF, 16'hA55A, 0, 16'h0000, 16'h5A5A, 0};
    tbl[7]  = '{0, 1, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 16'hA55A, 0};
    tbl[8]  = '{0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    tbl[9]  = '{0, 1, 0, 16'h0008, 16'h0000, 1, 16'h0009, 16'h0808, 0};
    tbl[10] = '{1, 0, 1, 16'h0000, 16'hC3C3, 0, 16'h0000, 16'h5A5A, 0};
    tbl[11] = '{1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'hC3C3, 0};
    tbl[12] = '{0, 1, 1, 16'h0005, 16'h0BAD, 0, 16'h0000, 16'h0808, 1};
    tbl[13] = '{1, 1, 0, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0BAD, 1};

    rst_b = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive_port(0, 0, 0, 16'h0, 16'h0);
    drive_port(1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    preload(16'h0010, 16'hBEEF);
    preload(16'h0001, 16'h1111);
    preload(16'h0002, 16'h2222);
    preload(16'h0008, 16'h0808);
    preload(16'h0009, 16'h0909);
    check("reset_outputs", outs(), 80'd0);
    rst_b = 1'b1;

    // Continuous contention from reset: grants must alternate p0,p1,p0,p1.
    @(negedge clk);
    drive_port(0, 1, 0, 16'h0001, 16'h0);
    drive_port(1, 1, 0, 16'h0002, 16'h0);
    for (int k = 0; k < 4; k++) begin
      e.port = k[0]; e.rdata = k[0] ? 16'h2222 : 16'h1111;
      sb.push_back(e);
    end
    n_en = 0; n_ack = 0; last_en = 0; last_ack = 0;
    for (int cyc = 1; cyc <= 20 && n_ack < 4; cyc++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        check("rr_addr", bus.mem_addr, (n_en % 2 == 0) ? 80'h0001 : 80'h0002);
        check("rr_en_gap", cyc - last_en, (n_en == 0) ? 80'd1 : 80'd3);
        last_en = cyc; n_en++;
      end
      if (bus.p0_ack || bus.p1_ack) begin
        check("rr_ack_gap", cyc - last_ack, (n_ack == 0) ? 80'd2 : 80'd3);
        last_ack = cyc; n_ack++;
        if (n_ack == 4) begin
          drive_port(0, 0, 0, 16'h0, 16'h0);
          drive_port(1, 0, 0, 16'h0, 16'h0);
        end
      end
    end
    check("rr_acks", n_ack, 80'd4);
    check("rr_grants", n_en, 80'd4);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      $display("vector %0d: port%0d rd=%0d wr=%0d addr=%h", i, tbl[i].port, tbl[i].rd,
               tbl[i].wr, tbl[i].addr);
      apply(tbl[i]);
    end

    // Reset in the ACCESS cycle of a p1 read aborts it; then a fresh access.
    @(negedge clk);
    drive_port(1, 1, 0, 16'h0002, 16'h0);
    @(negedge clk);
    check("abort_mem_en", bus.mem_en, 80'd1);
    #1 rst_b = 1'b0;
    #1 check("abort_outputs", outs(), 80'd0);
    @(negedge clk);
    check("abort_no_ack", outs(), 80'd0);
    rst_b = 1'b1;
    e.port = 1'b1; e.rdata = 16'h2222;
    sb.push_back(e);
    @(negedge clk);
    check("fresh_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {62'd0, 1'b1, 1'b0, 16'h0002});
    @(negedge clk);
    check("fresh_ack", {bus.p1_ack, bus.p0_ack}, 80'd2);
    drive_port(1, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    check("fresh_idle", {bus.busy, bus.err, bus.p0_rdata}, 80'd0);
    $display("reset abort sequence complete");

    @(negedge clk);
    check("sb_empty", sb.size(), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
